nand_gate_sweeper: RTL and testbench

Self-checking stimulus/response stage for the NAND-only logic unit. On `start` it walks (a,b) through 00, 01, 10, 11, drives each pair into the unit and waits a programmable settle time. It then samples the unit's six outputs (NOT a, NOT b, AND, OR, XOR, XNOR) and compares them against the expected truth table. It sits directly around the gate unit: it feeds the unit's `a`/`b` inputs and consumes its outputs, and reports pass/fail to the bench or system controller.

---
 rtl/nand_gate_sweeper.sv | 158 +++++++++++++++
 tb/tb_nand_gate_sweeper.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nand_gate_sweeper.sv
// Walks (a,b) through 00..11 around the NAND-only unit and checks its six outputs.
// Optional first-failure capture (fail_vec/fail_bits) under FIRST_FAIL_CAPTURE_EN.
module nand_gate_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic [5:0] res_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic [1:0] fail_vec,
  output logic [5:0] fail_bits
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_nxt_state;
  logic [3:0] r_cnt;
  logic [1:0] r_vec;
  logic [2:0] r_err;
  logic       r_pass;
  logic       r_done;
  logic       r_busy;

  logic       w_a;
  logic       w_b;
  logic [5:0] w_exp;
  logic [5:0] w_diff;
  logic       w_mis;
  logic       w_accept;
  logic       w_check;
  logic       w_last;

  assign w_a    = r_vec[1];
  assign w_b    = r_vec[0];
  assign w_exp  = {~w_a, ~w_b, w_a & w_b,
                   w_a | w_b, w_a ^ w_b,
                   ~(w_a ^ w_b)};
  assign w_diff = res_in ^ w_exp;
  assign w_mis  = |w_diff;

  assign w_accept = (r_state == S_IDLE) & start;
  assign w_check  = (r_state == S_CHECK);
  assign w_last   = w_check & (r_vec == 2'd3);

  always_comb begin
    w_nxt_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_nxt_state = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) w_nxt_state = S_CHECK;
      end
      S_CHECK: begin
        if (r_vec == 2'd3) w_nxt_state = S_IDLE;
        else               w_nxt_state = S_SETTLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= CNT_RELOAD;
    end else if (r_state == S_SETTLE) begin
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end else if (w_check && !w_last) begin
      r_cnt <= CNT_RELOAD;
    end
  end

  // The vector register doubles as the a/b drive, so it parks at 11.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec <= 2'd0;
    end else if (w_accept) begin
      r_vec <= 2'd0;
    end else if (w_check && !w_last) begin
      r_vec <= r_vec + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err  <= 3'd0;
      r_pass <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_err  <= 3'd0;
        r_pass <= 1'b0;
        r_busy <= 1'b1;
      end else if (w_check) begin
        if (w_mis) r_err <= r_err + 3'd1;
        if (w_last) begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_pass <= (r_err == 3'd0) & ~w_mis;
        end
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [1:0] r_fail_vec;
  logic [5:0] r_fail_bits;

  // An empty error count at a mismatch means it is the first of the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail_vec  <= 2'd0;
      r_fail_bits <= 6'd0;
    end else if (w_accept) begin
      r_fail_vec  <= 2'd0;
      r_fail_bits <= 6'd0;
    end else if (w_check && w_mis && (r_err == 3'd0)) begin
      r_fail_vec  <= r_vec;
      r_fail_bits <= w_diff;
    end
  end

  assign fail_vec  = r_fail_vec;
  assign fail_bits = r_fail_bits;
`endif

  assign a_out     = w_a;
  assign b_out     = w_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;

endmodule

// File: tb/tb_nand_gate_sweeper.sv
// Bench for nand_gate_sweeper: a NAND-built unit model with per-vector fault masks,
// two DUTs (SETTLE_CYCLES=1 and 3) sharing one start/reset.
module tb_nand_gate_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  always #5 clk = ~clk;

  logic [5:0] mask [4];

  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [5:0] res1;
  logic       a3, b3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [5:0] res3;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic [1:0] fv1, fv3;
  logic [5:0] fb1, fb3;
`endif

  int n_vec = 0;
  int n_err = 0;

  function automatic logic nd(input logic x, input logic y);
    return ~(x & y);
  endfunction

  // Unit model built from NAND gates only.
  function automatic logic [5:0] unit(input logic a, input logic b);
    logic na, nb, t, an, o, x, xn;
    na = nd(a, a);
    nb = nd(b, b);
    t  = nd(a, b);
    an = nd(t, t);
    o  = nd(na, nb);
    x  = nd(nd(a, t), nd(b, t));
    xn = nd(x, x);
    return {na, nb, an, o, x, xn};
  endfunction

  assign res1 = unit(a1, b1) ^ mask[{a1, b1}];
  assign res3 = unit(a3, b3) ^ mask[{a3, b3}];

  nand_gate_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a1), .b_out(b1), .res_in(res1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_vec(fv1), .fail_bits(fb1)
`endif
  );

  nand_gate_sweeper #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a3), .b_out(b3), .res_in(res3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_vec(fv3), .fail_bits(fb3)
`endif
  );

  typedef struct {
    logic [5:0] m [4];
    int         err;
    bit         pass;
    logic [1:0] fv;
    logic [5:0] fb;
  } rec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: count faulty vectors, first faulty one and its mask.
  function automatic rec_t model(input logic [5:0] m [4]);
    rec_t r;
    r.m    = m;
    r.err  = 0;
    r.fv   = 2'd0;
    r.fb   = 6'd0;
    for (int v = 0; v < 4; v++) begin
      if (m[v] != 6'd0) begin
        if (r.err == 0) begin
          r.fv = 2'(v);
          r.fb = m[v];
        end
        r.err++;
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  task automatic chk_results(input rec_t r, input string tag);
    chk({tag, " err1"}, err1, r.err);
    chk({tag, " pass1"}, pass1, r.pass);
    chk({tag, " err3"}, err3, r.err);
    chk({tag, " pass3"}, pass3, r.pass);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk({tag, " fv1"}, fv1, r.fv);
    chk({tag, " fb1"}, fb1, r.fb);
    chk({tag, " fv3"}, fv3, r.fv);
    chk({tag, " fb3"}, fb3, r.fb);
`endif
  endtask

  task automatic sweep(input rec_t r, input bit repulse, input string tag);
    int x1, x3;
    for (int v = 0; v < 4; v++) mask[v] = r.m[v];
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) start = 1'b0;
      if (repulse && e == 4) start = 1'b1;
      if (repulse && e == 5) start = 1'b0;
      x1 = (e / 2 > 3) ? 3 : e / 2;
      x3 = (e / 4 > 3) ? 3 : e / 4;
      chk({tag, " ab1"}, {a1, b1}, x1);
      chk({tag, " ab3"}, {a3, b3}, x3);
      chk({tag, " done1"}, done1, int'(e == 8));
      chk({tag, " done3"}, done3, int'(e == 16));
      chk({tag, " busy1"}, busy1, int'(e < 8));
      chk({tag, " busy3"}, busy3, int'(e < 16));
    end
    chk_results(r, tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ab1"}, {a1, b1}, 0);
    chk({tag, " ab3"}, {a3, b3}, 0);
    chk({tag, " busy"}, {busy1, busy3}, 0);
    chk({tag, " done"}, {done1, done3}, 0);
    chk({tag, " pass"}, {pass1, pass3}, 0);
    chk({tag, " err1"}, err1, 0);
    chk({tag, " err3"}, err3, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk({tag, " fail"}, {fv1, fb1, fv3, fb3}, 0);
`endif
  endtask

  rec_t tbl [3];
  rec_t rr;
  logic [5:0] rm [4];

  initial begin
    tbl[0].m = '{6'h00, 6'h00, 6'h00, 6'h00};
    tbl[0].err = 0; tbl[0].pass = 1;
    tbl[0].fv = 2'd0; tbl[0].fb = 6'd0;
    tbl[1].m = '{6'h00, 6'b000010, 6'b000010, 6'h00};
    tbl[1].err = 2; tbl[1].pass = 0;
    tbl[1].fv = 2'b01; tbl[1].fb = 6'b000010;
    tbl[2].m = '{6'b110001, 6'b101110, 6'b011110, 6'b001101};
    tbl[2].err = 4; tbl[2].pass = 0;
    tbl[2].fv = 2'b00; tbl[2].fb = 6'b110001;

    for (int v = 0; v < 4; v++) mask[v] = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++)
      sweep(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // Start re-pulsed while busy must be ignored.
    sweep(tbl[1], 1'b1, "repulse");

    for (int k = 0; k < 8; k++) begin
      for (int v = 0; v < 4; v++)
        rm[v] = ($urandom_range(0, 1) == 1) ?
                6'($urandom_range(1, 63)) : 6'd0;
      rr = model(rm);
      sweep(rr, 1'b0, $sformatf("rnd%0d", k));
    end

    // Reset at edge 4 of a sweep.
    mask = tbl[1].m;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      chk("midrst nodone", {done1, done3}, 0);
    end
    sweep(tbl[0], 1'b0, "postrst");

    // Start held through the done cycle: back-to-back sweep on dut1.
    mask = tbl[2].m;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 8) chk("b2b err_at_done", err1, 4);
      if (e == 9) begin
        chk("b2b err_clr", err1, 0);
        chk("b2b busy", busy1, 1);
        chk("b2b ab", {a1, b1}, 0);
        start = 1'b0;
      end
      chk("b2b done1", done1, int'(e == 8 || e == 17));
      chk("b2b done3", done3, int'(e == 16));
    end
    chk_results(tbl[2], "b2b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
